// File: rtl/tri_bbox_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tri_bbox_scanner
// Description : Latches a triangle, computes its screen-clipped bounding box
//               and streams every candidate pixel in raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_bbox_scanner #(
    parameter int COORD_W = 10,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] p1x,
    input  logic [COORD_W-1:0] p1y,
    input  logic [COORD_W-1:0] p2x,
    input  logic [COORD_W-1:0] p2y,
    input  logic [COORD_W-1:0] p3x,
    input  logic [COORD_W-1:0] p3y,
    output logic [COORD_W-1:0] v1x,
    output logic [COORD_W-1:0] v1y,
    output logic [COORD_W-1:0] v2x,
    output logic [COORD_W-1:0] v2y,
    output logic [COORD_W-1:0] v3x,
    output logic [COORD_W-1:0] v3y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] ptx,
    output logic [COORD_W-1:0] pty,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_bbox = 2'd1;
    localparam logic [1:0] c_scan = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam logic [COORD_W-1:0] c_x_max = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] c_y_max = COORD_W'(Y_MAX);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [COORD_W-1:0] r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y;
    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [COORD_W-1:0] r_ptx, r_pty;
    logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic               w_tri_ready;
    logic               w_last;
    logic               w_offscreen;

    // Unclipped minima/maxima over the latched vertices, then clip the maxima.
    always_comb begin
        w_xmin = r_v1x;
        w_xmax = r_v1x;
        w_ymin = r_v1y;
        w_ymax = r_v1y;
        if (r_v2x < w_xmin) w_xmin = r_v2x;
        if (r_v3x < w_xmin) w_xmin = r_v3x;
        if (r_v2x > w_xmax) w_xmax = r_v2x;
        if (r_v3x > w_xmax) w_xmax = r_v3x;
        if (r_v2y < w_ymin) w_ymin = r_v2y;
        if (r_v3y < w_ymin) w_ymin = r_v3y;
        if (r_v2y > w_ymax) w_ymax = r_v2y;
        if (r_v3y > w_ymax) w_ymax = r_v3y;
        if (w_xmax > c_x_max) w_xmax = c_x_max;
        if (w_ymax > c_y_max) w_ymax = c_y_max;
    end

    assign w_offscreen = (w_xmin > c_x_max) || (w_ymin > c_y_max);
    assign w_tri_ready = (r_state == c_idle) && !rst;
    assign w_last      = (r_state == c_scan) && (r_ptx == r_xmax) && (r_pty == r_ymax);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (tri_valid && w_tri_ready) w_state_nxt = c_bbox;
            c_bbox:  w_state_nxt = w_offscreen ? c_done : c_scan;
            c_scan:  if (pix_ready && w_last) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_v1x   <= '0;
            r_v1y   <= '0;
            r_v2x   <= '0;
            r_v2y   <= '0;
            r_v3x   <= '0;
            r_v3y   <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymin  <= '0;
            r_ymax  <= '0;
            r_ptx   <= '0;
            r_pty   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_idle: begin
                    if (tri_valid && w_tri_ready) begin
                        r_v1x <= p1x;
                        r_v1y <= p1y;
                        r_v2x <= p2x;
                        r_v2y <= p2y;
                        r_v3x <= p3x;
                        r_v3y <= p3y;
                    end
                end
                c_bbox: begin
                    r_xmin <= w_xmin;
                    r_xmax <= w_xmax;
                    r_ymin <= w_ymin;
                    r_ymax <= w_ymax;
                    if (!w_offscreen) begin
                        r_ptx <= w_xmin;
                        r_pty <= w_ymin;
                    end
                end
                c_scan: begin
                    // Increments are bounded by the clipped maxima, so no wrap.
                    if (pix_ready) begin
                        if (r_ptx < r_xmax) begin
                            r_ptx <= r_ptx + 1'b1;
                        end else if (r_pty < r_ymax) begin
                            r_ptx <= r_xmin;
                            r_pty <= r_pty + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tri_ready = w_tri_ready;
    assign busy      = (r_state != c_idle);
    assign done      = (r_state == c_done);
    assign pix_valid = (r_state == c_scan);
    assign last      = w_last;
    assign ptx       = r_ptx;
    assign pty       = r_pty;
    assign v1x       = r_v1x;
    assign v1y       = r_v1y;
    assign v2x       = r_v2x;
    assign v2y       = r_v2y;
    assign v3x       = r_v3x;
    assign v3y       = r_v3y;

endmodule
`default_nettype wire

// File: tb/tb_tri_bbox_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_bbox_scanner
// Description : Directed vector bench for tri_bbox_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_bbox_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       tri_valid;
    logic       tri_ready;
    logic [9:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic [9:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] ptx, pty;
    logic       last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x1, y1, x2, y2, x3, y3;
        int xmin, xmax, ymin, ymax;
        bit off;
    } vec_t;

    vec_t vecs[7];

    tri_bbox_scanner #(.COORD_W(10), .X_MAX(639), .Y_MAX(479)) dut (
        .clk(clk), .rst(rst),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .ptx(ptx), .pty(pty), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_tri(input int i);
        p1x = 10'(vecs[i].x1); p1y = 10'(vecs[i].y1);
        p2x = 10'(vecs[i].x2); p2y = 10'(vecs[i].y2);
        p3x = 10'(vecs[i].x3); p3y = 10'(vecs[i].y3);
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
    endtask

    // Full scan with pix_ready held high; pixel order comes from the expected box.
    task automatic run_tri(input int i);
        int ex, ey, n, w, h;
        chk($sformatf("v%0d idle tri_ready", i), int'(tri_ready), 1);
        send_tri(i);
        chk($sformatf("v%0d bbox state", i), {busy, tri_ready, pix_valid}, 3'b100);
        chk($sformatf("v%0d latched v", i), {v1x, v2y, v3x}, {10'(vecs[i].x1), 10'(vecs[i].y2), 10'(vecs[i].x3)});
        tick();
        if (!vecs[i].off) begin
            w = vecs[i].xmax - vecs[i].xmin + 1;
            h = vecs[i].ymax - vecs[i].ymin + 1;
            n = w * h;
            for (int k = 0; k < n; k++) begin
                ex = vecs[i].xmin + (k % w);
                ey = vecs[i].ymin + (k / w);
                chk($sformatf("v%0d pix%0d valid/x/y/last", i, k),
                    {pix_valid, ptx, pty, last},
                    {1'b1, 10'(ex), 10'(ey), (k == n - 1) ? 1'b1 : 1'b0});
                tick();
            end
        end
        chk($sformatf("v%0d done pulse", i), {done, pix_valid, busy}, 3'b101);
        tick();
        chk($sformatf("v%0d back idle", i), {tri_ready, done, busy}, 3'b100);
    endtask

    initial begin
        int k, px[6], py[6];
        vecs[0] = '{0, 0, 2, 0, 0, 1,          0, 2, 0, 1, 1'b0};
        vecs[1] = '{5, 7, 5, 7, 5, 7,          5, 5, 7, 7, 1'b0};
        vecs[2] = '{700, 10, 710, 20, 705, 30, 0, 0, 0, 0, 1'b1};
        vecs[3] = '{630, 470, 700, 500, 635, 475, 630, 639, 470, 479, 1'b0};
        vecs[4] = '{3, 4, 3, 9, 3, 6,          3, 3, 4, 9, 1'b0};
        vecs[5] = '{20, 12, 17, 15, 22, 11,    17, 22, 11, 15, 1'b0};
        vecs[6] = '{10, 480, 20, 490, 5, 500,  0, 0, 0, 0, 1'b1};
        px = '{0, 1, 2, 0, 1, 2};
        py = '{0, 0, 0, 1, 1, 1};

        rst = 1'b1; tri_valid = 1'b0; pix_ready = 1'b1;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        tick(); tick();
        chk("reset outputs", {tri_ready, busy, pix_valid, last, done}, 5'b00000);
        chk("reset regs", {ptx, pty, v1x, v3y}, 40'd0);
        rst = 1'b0;
        tick();
        chk("post-reset tri_ready", int'(tri_ready), 1);

        for (int i = 0; i < 7; i++) run_tri(i);

        // Backpressure 1,0,0,1,... with tri_valid held high while busy.
        send_tri(0);
        p1x = 10'd99; tri_valid = 1'b1;
        tick();
        k = 0;
        for (int c = 0; c < 60; c++) begin
            pix_ready = (c % 4 == 0 || c % 4 == 3);
            #1;
            if (!pix_valid) break;
            chk($sformatf("bp cyc%0d tri_ready", c), int'(tri_ready), 0);
            chk($sformatf("bp cyc%0d x/y/last", c), {ptx, pty, last},
                {10'(px[k]), 10'(py[k]), (k == 5) ? 1'b1 : 1'b0});
            if (pix_ready) k++;
            tick();
        end
        chk("bp pixel count", k, 6);
        chk("bp done", int'(done), 1);
        chk("bp v1x held", int'(v1x), 0);
        tri_valid = 1'b0; pix_ready = 1'b1;
        tick();
        chk("bp back idle", {tri_ready, busy}, 2'b10);

        // Reset at pixel (1,0) abandons the triangle.
        send_tri(0);
        tick(); tick();
        chk("rst pre pixel", {pix_valid, ptx, pty}, {1'b1, 10'd1, 10'd0});
        rst = 1'b1;
        tick();
        chk("rst mid-scan", {pix_valid, busy, done, tri_ready}, 4'b0000);
        rst = 1'b0;
        tick();
        chk("rst release", {tri_ready, done, busy}, 3'b100);
        run_tri(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
